ref_row_streamer: RTL and testbench
===================================

# ref_row_streamer

Fetches the reference-pixel window for one 8x8 block from frame memory and streams it, one 15-pixel row per handshake, into the subpixel interpolation datapath's row input. It is the producer side of the interpolator's row interface. It generates frame-memory addresses, applies HEVC edge padding by coordinate clamping, and packs pixels into the 120-bit row word the FIR bank consumes. It sits between the frame-memory read port and the interpolator's `in_row` input.

## Interface
- FRAME_W, 64: frame width in pixels; power of two.
- FRAME_H, 64: frame height in pixels; power of two.
- COORD_W, 8: block coordinate width; 2^COORD_W ≥ max(FRAME_W, FRAME_H).
- ADDR_W, 12: memory address width, log2(FRAME_W*FRAME_H).

Ports:
- clk  in  1  clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- blk_x  in  COORD_W  block origin column, unsigned, captured on start.
- blk_y  in  COORD_W  block origin row, unsigned, captured on start.
- busy  out  1  high from the cycle after an accepted start until the cycle after done.
- mem_rd  out  1  read strobe.
- mem_addr  out  ADDR_W  pixel address = y*FRAME_W + x.
- mem_rdata  in  8  pixel; valid exactly one cycle after mem_rd.
- out_row  out  120  15 pixels; pixel i in [8i+:8], i=0 leftmost.
- row_valid  out  1  out_row is stable and offered.
- row_ready  in  1  consumer accepts when row_valid and row_ready are both high.
- row_idx  out  4  row number 0..14 of out_row.
- last_row  out  1  high with row_valid when row_idx==14.
- done  out  1  one-cycle pulse after the row-14 handshake.

## Operation
- FSM states: IDLE, FETCH, WAIT, PRESENT, DONE.
- IDLE -> FETCH on start. Latch blk_x and blk_y. Clear the row counter r and the pixel counter i.
- FETCH: assert mem_rd for 15 consecutive cycles, i=0..14.
  - x = blk_x − 3 + i.
  - y = blk_y − 3 + r.
  - Both are computed signed, COORD_W+2 bits, then clamped to [0, FRAME_W−1] and [0, FRAME_H−1].
  - After i=14 -> WAIT.
- Data capture: each mem_rdata is captured the cycle after its read into assembly slot i (delayed index). WAIT covers the final capture, then -> PRESENT.
- PRESENT: row_valid=1 and out_row is frozen.
  - On handshake with r<14: r+=1, -> FETCH.
  - On handshake with r==14: -> DONE.
  - While row_ready is low, hold all outputs indefinitely.
- DONE: done=1 for one cycle, -> IDLE.
- start outside IDLE is ignored.
- row_ready while row_valid is low has no effect.
- No reads are issued outside FETCH, so a row is never overwritten before it is accepted.
- Reset at any point:
  - Next state is IDLE.
  - Any outstanding read return is discarded.
  - All outputs become 0.

## Timing
- Reset values: busy=0, mem_rd=0, mem_addr=0, out_row=0, row_valid=0, row_idx=0, last_row=0, done=0.
- Cycle 0 is the cycle in which start is sampled. With row_ready held high, row r occupies:
  - FETCH: cycles 1+17r .. 15+17r.
  - WAIT: cycle 16+17r.
  - PRESENT: cycle 17+17r.
- Full block, row_ready always high:
  - row 14 is presented in cycle 255;
  - done is high in cycle 256;
  - busy falls in cycle 257.
- Each cycle of row_ready low in PRESENT adds exactly one cycle.
- Latency from start to first row_valid is 17 cycles.

## Structure
- Shared package interp_pkg holds:
  - PIX_W=8, TAPS=8, TAP_LEFT=3, BLK=8;
  - ROW_PIX = BLK+TAPS−1 = 15;
  - ROW_W = ROW_PIX*PIX_W = 120;
  - the FSM state encoding.
- The interpolator side imports the same package.
- One sub-module: coord_clamp (signed in, lo/hi bounds, unsigned out). It is instantiated twice, once for x and once for y.

## Test plan
All scenarios use FRAME_W=FRAME_H=64 and a memory model where pixel(x,y) = (x + 2y) & 0xFF, with 1-cycle read latency.

- Interior block (16,16), row_ready=1:
  - row 0: pixel0=39, pixel14=53;
  - row 14: pixel0=67;
  - first row_valid at cycle 17; done at cycle 256.
- Top-left corner (0,0):
  - rows 0..3 are identical: pixels 0..3 = 0, pixel14 = 11;
  - row 4: pixel0 = 2.
- Bottom-right corner (56,56):
  - row 14: pixel0 = 179, pixel14 = 189;
  - rows 11..14 are identical.
- Backpressure: drop row_ready for 5 cycles on row 7. Required response:
  - out_row, row_idx and row_valid stay stable;
  - mem_rd stays 0;
  - done arrives at cycle 261.
- Reset mid-block: rst in cycle 100. Required response:
  - next cycle, all outputs are 0;
  - a fresh start then behaves exactly like the interior-block scenario.
- Start while busy: a second start pulse at cycle 50 is ignored. The block still completes with origin from the first start and a single done pulse.

Source files
------------

// File: rtl/interp_pkg.sv
// Shared constants and FSM encoding for the reference-row streamer and the
// subpixel interpolator that consumes its rows.
package interp_pkg;

   localparam int PIX_W    = 8;
   localparam int TAPS     = 8;
   localparam int TAP_LEFT = 3;
   localparam int BLK      = 8;
   localparam int ROW_PIX  = BLK + TAPS - 1;
   localparam int ROW_W    = ROW_PIX * PIX_W;

   localparam logic [3:0] LAST_IDX = 4'(ROW_PIX - 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_WAIT,
      ST_PRESENT,
      ST_DONE
   } state_t;

endpackage

// File: rtl/ref_row_streamer_if.sv
// Control, frame-memory read port and row-stream signals of the reference-row
// streamer; master is the streamer, slave is its environment.
interface ref_row_streamer_if #(
   parameter int COORD_W = 8,
   parameter int ADDR_W  = 12
);
   import interp_pkg::*;

   logic               start;
   logic [COORD_W-1:0] blk_x;
   logic [COORD_W-1:0] blk_y;
   logic               busy;
   logic               mem_rd;
   logic [ADDR_W-1:0]  mem_addr;
   logic [PIX_W-1:0]   mem_rdata;
   logic [ROW_W-1:0]   out_row;
   logic               row_valid;
   logic               row_ready;
   logic [3:0]         row_idx;
   logic               last_row;
   logic               done;

   modport master (
      input  start, blk_x, blk_y, mem_rdata, row_ready,
      output busy, mem_rd, mem_addr, out_row, row_valid, row_idx, last_row, done
   );

   modport slave (
      output start, blk_x, blk_y, mem_rdata, row_ready,
      input  busy, mem_rd, mem_addr, out_row, row_valid, row_idx, last_row, done
   );

endinterface

// File: rtl/coord_clamp.sv
// Clamps a signed coordinate into [lo, hi] and returns it as an unsigned
// value narrow enough to index the frame; this is what implements edge padding.
module coord_clamp #(
   parameter int IN_W  = 10,
   parameter int OUT_W = 6
) (
   input  logic signed [IN_W-1:0] i_val,
   input  logic signed [IN_W-1:0] i_lo,
   input  logic signed [IN_W-1:0] i_hi,
   output logic [OUT_W-1:0]       o_val
);

   logic signed [IN_W-1:0] w_sel;

   assign w_sel = (i_val < i_lo) ? i_lo :
                  (i_val > i_hi) ? i_hi : i_val;

   assign o_val = w_sel[OUT_W-1:0];

endmodule

// File: rtl/ref_row_streamer.sv
// Fetches the 15x15 reference window around an 8x8 block, clamping coordinates
// at frame edges, and offers it one packed 15-pixel row per handshake.
module ref_row_streamer
   import interp_pkg::*;
#(
   parameter int FRAME_W = 64,
   parameter int FRAME_H = 64,
   parameter int COORD_W = 8,
   parameter int ADDR_W  = 12
) (
   input  logic            clk,
   input  logic            rst,
   ref_row_streamer_if.master bus
);

   localparam int CW = COORD_W + 2;
   localparam int XB = $clog2(FRAME_W);
   localparam int YB = $clog2(FRAME_H);

   localparam logic signed [CW-1:0] C_LO = '0;
   localparam logic signed [CW-1:0] X_HI = CW'(FRAME_W - 1);
   localparam logic signed [CW-1:0] Y_HI = CW'(FRAME_H - 1);
   localparam logic signed [CW-1:0] C_OFF = CW'(TAP_LEFT);

   state_t r_state;
   state_t w_next;

   logic [COORD_W-1:0] r_blkX;
   logic [COORD_W-1:0] r_blkY;
   logic [3:0]         r_row;
   logic [3:0]         r_pix;
   logic               r_capV;
   logic [3:0]         r_capIdx;
   logic [ROW_W-1:0]   r_asm;

   logic               w_rd;
   logic               w_valid;
   logic               w_done;
   logic               w_busy;
   logic signed [CW-1:0] w_xRaw;
   logic signed [CW-1:0] w_yRaw;
   logic [XB-1:0]      w_xC;
   logic [YB-1:0]      w_yC;
   logic [ADDR_W-1:0]  w_addr;

   assign w_xRaw = $signed({2'b00, r_blkX}) + $signed({{(CW-4){1'b0}}, r_pix}) - C_OFF;
   assign w_yRaw = $signed({2'b00, r_blkY}) + $signed({{(CW-4){1'b0}}, r_row}) - C_OFF;

   coord_clamp #(.IN_W(CW), .OUT_W(XB)) u_clampX (
      .i_val (w_xRaw),
      .i_lo  (C_LO),
      .i_hi  (X_HI),
      .o_val (w_xC)
   );

   coord_clamp #(.IN_W(CW), .OUT_W(YB)) u_clampY (
      .i_val (w_yRaw),
      .i_lo  (C_LO),
      .i_hi  (Y_HI),
      .o_val (w_yC)
   );

   // Power-of-two frame width turns y*FRAME_W + x into a concatenation.
   assign w_addr = ADDR_W'({w_yC, w_xC});

   always_ff @(posedge clk) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next  = r_state;
      w_rd    = 1'b0;
      w_valid = 1'b0;
      w_done  = 1'b0;
      w_busy  = 1'b1;
      case (r_state)
         ST_IDLE: begin
            w_busy = 1'b0;
            if (bus.start) w_next = ST_FETCH;
         end
         ST_FETCH: begin
            w_rd = 1'b1;
            if (r_pix == LAST_IDX) w_next = ST_WAIT;
         end
         ST_WAIT: w_next = ST_PRESENT;
         ST_PRESENT: begin
            w_valid = 1'b1;
            if (bus.row_ready) w_next = (r_row == LAST_IDX) ? ST_DONE : ST_FETCH;
         end
         ST_DONE: begin
            w_done = 1'b1;
            w_next = ST_IDLE;
         end
         default: w_next = ST_IDLE;
      endcase
   end

   // Read data returns one cycle late, so the slot index is delayed alongside it.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_blkX   <= '0;
         r_blkY   <= '0;
         r_row    <= '0;
         r_pix    <= '0;
         r_capV   <= 1'b0;
         r_capIdx <= '0;
         r_asm    <= '0;
      end else begin
         r_capV   <= w_rd;
         r_capIdx <= r_pix;
         if (r_capV) r_asm[r_capIdx*PIX_W +: PIX_W] <= bus.mem_rdata;
         if (r_state == ST_IDLE && bus.start) begin
            r_blkX <= bus.blk_x;
            r_blkY <= bus.blk_y;
            r_row  <= '0;
            r_pix  <= '0;
         end else if (r_state == ST_FETCH) begin
            r_pix <= r_pix + 4'd1;
         end else if (r_state == ST_PRESENT && bus.row_ready && r_row != LAST_IDX) begin
            r_row <= r_row + 4'd1;
            r_pix <= '0;
         end
      end
   end

   assign bus.busy      = w_busy;
   assign bus.mem_rd    = w_rd;
   assign bus.mem_addr  = w_rd ? w_addr : '0;
   assign bus.out_row   = r_asm;
   assign bus.row_valid = w_valid;
   assign bus.row_idx   = r_row;
   assign bus.last_row  = w_valid && (r_row == LAST_IDX);
   assign bus.done      = w_done;

endmodule

// File: tb/tb_ref_row_streamer.sv
// Directed bench for ref_row_streamer against a frame memory holding
// pixel(x,y) = (x + 2y) & 0xFF with one-cycle read latency.
module tb_ref_row_streamer;
   import interp_pkg::*;

   logic clk;
   logic rst;

   int checks;
   int errors;
   int cyc;

   logic [ROW_W-1:0] rows [ROW_PIX];
   logic [ROW_W-1:0] expRow;
   int firstValid, doneCyc, busyFall, doneCnt, stableBad, lastBad;
   bit timedOut;
   int rel;

   ref_row_streamer_if #(.COORD_W(8), .ADDR_W(12)) bus ();

   ref_row_streamer #(
      .FRAME_W (64),
      .FRAME_H (64),
      .COORD_W (8),
      .ADDR_W  (12)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (bus.mem_rd) bus.mem_rdata <= 8'({2'b00, bus.mem_addr[5:0]} + {1'b0, bus.mem_addr[11:6], 1'b0});
      else            bus.mem_rdata <= 8'hEE;
   end

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Runs one block; optional stall on one row and optional stray start.
   task automatic applyStimulus(input logic [7:0] bx, input logic [7:0] by,
                                input int stallRow, input int stallLen, input int restartAt);
      int stallCnt;
      bit finished;
      logic [ROW_W-1:0] snapRow;
      logic [3:0] snapIdx;
      for (int i = 0; i < ROW_PIX; i++) rows[i] = '0;
      firstValid = -1; doneCyc = -1; busyFall = -1;
      doneCnt = 0; stableBad = 0; lastBad = 0;
      snapRow = '0; snapIdx = '0;
      bus.row_ready = 1'b1;
      bus.blk_x = bx;
      bus.blk_y = by;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      rel = 1;
      stallCnt = 0;
      finished = 0;
      while (!finished && rel < 400) begin
         if (bus.last_row !== (bus.row_valid && bus.row_idx == 4'd14)) lastBad++;
         if (bus.row_valid && firstValid < 0) firstValid = rel;
         if (bus.done) begin
            doneCnt++;
            if (doneCyc < 0) doneCyc = rel;
         end
         if (!bus.busy && busyFall < 0) begin
            busyFall = rel;
            finished = 1;
         end
         if (bus.row_valid && int'(bus.row_idx) == stallRow && stallCnt < stallLen) begin
            if (stallCnt == 0) begin
               snapRow = bus.out_row;
               snapIdx = bus.row_idx;
            end else if (bus.out_row !== snapRow || bus.row_idx !== snapIdx || bus.row_valid !== 1'b1) begin
               stableBad++;
            end
            if (bus.mem_rd !== 1'b0) stableBad++;
            stallCnt++;
            bus.row_ready = 1'b0;
         end else begin
            bus.row_ready = 1'b1;
            if (bus.row_valid) rows[bus.row_idx] = bus.out_row;
         end
         bus.start = (rel == restartAt);
         if (rel == restartAt) begin
            bus.blk_x = 8'd56;
            bus.blk_y = 8'd56;
         end
         if (!finished) begin
            tick();
            rel++;
         end
      end
      bus.start = 1'b0;
      timedOut = !finished;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      cyc = 0;
      rst = 1'b1;
      bus.start = 1'b0;
      bus.blk_x = '0;
      bus.blk_y = '0;
      bus.row_ready = 1'b0;
      tick();
      tick();
      checkOutput("reset_busy_rd_valid_done", {bus.busy, bus.mem_rd, bus.row_valid, bus.last_row, bus.done}, 5'b0);
      checkOutput("reset_addr_idx", {bus.mem_addr, bus.row_idx}, 16'h0);
      checkOutput("reset_out_row", bus.out_row, 128'h0);
      rst = 1'b0;
      tick();

      // Interior block.
      applyStimulus(8'd16, 8'd16, -1, 0, -1);
      checkOutput("int_timeout", timedOut, 1'b0);
      checkOutput("int_first_valid", firstValid, 17);
      checkOutput("int_done_cycle", doneCyc, 256);
      checkOutput("int_busy_fall", busyFall, 257);
      checkOutput("int_done_count", doneCnt, 1);
      checkOutput("int_last_row", lastBad, 0);
      for (int i = 0; i < ROW_PIX; i++) expRow[i*8 +: 8] = 8'(39 + i);
      checkOutput("int_row0", rows[0], expRow);
      checkOutput("int_row0_p14", rows[0][119:112], 8'd53);
      checkOutput("int_row7_p7", rows[7][63:56], 8'd60);
      checkOutput("int_row14_p0", rows[14][7:0], 8'd67);

      // Top-left corner.
      tick();
      applyStimulus(8'd0, 8'd0, -1, 0, -1);
      for (int i = 0; i < ROW_PIX; i++) expRow[i*8 +: 8] = (i < 3) ? 8'd0 : 8'(i - 3);
      checkOutput("tl_row0", rows[0], expRow);
      checkOutput("tl_row0_p14", rows[0][119:112], 8'd11);
      checkOutput("tl_row1_eq", rows[1], expRow);
      checkOutput("tl_row3_eq", rows[3], expRow);
      checkOutput("tl_row4_p0", rows[4][7:0], 8'd2);

      // Bottom-right corner.
      tick();
      applyStimulus(8'd56, 8'd56, -1, 0, -1);
      for (int i = 0; i < ROW_PIX; i++) expRow[i*8 +: 8] = 8'(((53 + i > 63) ? 63 : 53 + i) + 126);
      checkOutput("br_row14", rows[14], expRow);
      checkOutput("br_row14_p0_p14", {rows[14][7:0], rows[14][119:112]}, {8'd179, 8'd189});
      checkOutput("br_row11_eq", rows[11], expRow);

      // Backpressure on row 7.
      tick();
      applyStimulus(8'd16, 8'd16, 7, 5, -1);
      checkOutput("bp_stable", stableBad, 0);
      checkOutput("bp_done_cycle", doneCyc, 261);
      checkOutput("bp_row7_p0", rows[7][7:0], 8'd53);

      // Reset in cycle 100 of a block.
      tick();
      bus.row_ready = 1'b1;
      bus.blk_x = 8'd56;
      bus.blk_y = 8'd56;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      rel = 1;
      while (rel < 100) begin
         tick();
         rel++;
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checkOutput("rst_mid_ctrl", {bus.busy, bus.mem_rd, bus.row_valid, bus.last_row, bus.done}, 5'b0);
      checkOutput("rst_mid_addr_idx", {bus.mem_addr, bus.row_idx}, 16'h0);
      checkOutput("rst_mid_out_row", bus.out_row, 128'h0);
      tick();
      applyStimulus(8'd16, 8'd16, -1, 0, -1);
      for (int i = 0; i < ROW_PIX; i++) expRow[i*8 +: 8] = 8'(39 + i);
      checkOutput("rst_after_row0", rows[0], expRow);
      checkOutput("rst_after_first_valid", firstValid, 17);
      checkOutput("rst_after_done_cycle", doneCyc, 256);

      // Stray start while busy.
      tick();
      applyStimulus(8'd16, 8'd16, -1, 0, 50);
      checkOutput("sb_done_count", doneCnt, 1);
      checkOutput("sb_done_cycle", doneCyc, 256);
      checkOutput("sb_row0_p0", rows[0][7:0], 8'd39);
      checkOutput("sb_row14_p0", rows[14][7:0], 8'd67);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
